// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter and its downstream
// 8-to-3 one-hot encoder.
package rr_arbiter8_pkg;

  localparam int NREQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index of the set bit in a one-hot vector; zero when the vector is empty.
  function automatic logic [2:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first requester at or above ptr,
// wrapping 7->0, returned one-hot.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] pick
);

  logic [NREQ-1:0]   mask;
  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] lowest;

  // Lower half keeps only requesters at/above ptr; the upper half supplies
  // the wrapped candidates, so the lowest set bit of the pair is the winner.
  always_comb begin
    mask   = ~((NREQ'(1) << ptr) - NREQ'(1));
    dbl    = {req, req & mask};
    lowest = dbl & (-dbl);
    pick   = lowest[NREQ-1:0] | lowest[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot-or-zero grant,
// owner release and bounded hold time.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            release_pulse,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic            timeout
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t          state, state_next;
  logic [2:0]      ptr, ptr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [NREQ-1:0] grant_next;
  logic [NREQ-1:0] pick;
  logic            timeout_next;
  logic            hold_expired;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    cnt_next     = cnt;
    grant_next   = grant;
    timeout_next = 1'b0;
    hold_expired = (MAX_HOLD != 0) && (cnt == CNT_LAST);
    case (state)
      IDLE: begin
        grant_next = '0;
        if (req != '0) begin
          grant_next = pick;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Release wins over a coincident expiry, so no timeout pulse then.
        if (release_pulse || hold_expired) begin
          grant_next   = '0;
          state_next   = IDLE;
          ptr_next     = onehot_to_idx(grant) + 3'd1;
          timeout_next = !release_pulse;
        end else if (cnt != '1) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cnt         <= cnt_next;
      grant       <= grant_next;
      grant_valid <= |grant_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that produces a registered one-hot grant vector. It sits directly upstream of the 8-to-3 one-hot encoder: `grant` drives the encoder input, and the encoder converts it to a 3-bit index plus a valid bit for the shared-resource mux. The arbiter enforces strict one-hot-or-zero output, fair rotation, and a bounded hold time. The encoder can therefore never see a multi-hot code.

## Interface
- `MAX_HOLD`, default 16: maximum cycles a grant may be held before forced revocation; 0 disables the timeout.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 8: request lines; `req[i]` high means requester i wants the resource. Level-sensitive.
- `release` input 1: one-cycle pulse from the current owner ending its grant.
- `grant` output 8: registered grant, either one-hot or all-zero.
- `grant_valid` output 1: registered, equals `|grant`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by `MAX_HOLD` expiry.

Reset is asynchronous and active-low, with one clock `clk`.

## Operation
- **Reset values:**
  - `grant`=8'h00, `grant_valid`=0, `timeout`=0.
  - Internal: state=IDLE, rotation pointer `ptr`=3'd0, hold counter `cnt`=0.
- **States:** IDLE and BUSY.
- **IDLE:**
  - If `req`≠0, choose the first set bit scanning upward from index `ptr`, wrapping 7→0.
  - Register the one-hot `grant`, set `grant_valid`=1, clear `cnt`, and go to BUSY.
  - If `req`=0, stay in IDLE.
  - `release` is ignored in IDLE.
- **BUSY:**
  - `grant` is held stable, and `cnt` increments each cycle.
  - `req` changes are ignored, including the owner dropping its request.
  - The grant ends on `release`=1, or when `MAX_HOLD`≠0 and `cnt`==`MAX_HOLD`-1.
  - On grant end: next cycle `grant`=0, `grant_valid`=0, state=IDLE, and `ptr`=(granted index+1) mod 8.
- **Timeout:** `timeout`=1 for exactly the cycle in which `grant` first reads zero after an expiry-driven end.
- **Simultaneous `release` and expiry:** treated as `release`, so no `timeout` pulse.
- **Idle gap:** there is always at least one all-zero `grant` cycle between two grants. The grant never switches directly from one one-hot value to another.
- **Counter width:** `cnt` is $clog2(`MAX_HOLD`+1) bits and saturates. When `MAX_HOLD`=0 it has no effect.
- **Reset mid-BUSY:** outputs clear asynchronously and `ptr` returns to 0. A pending `release` is discarded.

## Timing
- **Request to grant latency:** 1 cycle. With `req` sampled at edge k in IDLE, `grant` is valid after edge k.
- **Release to grant clear:** 1 cycle. With `release` sampled at edge k, `grant`=0 after edge k.
- **Re-arbitration:** earliest at the following edge, so back-to-back grants are spaced ≥2 cycles.
- **Timed-out grant hold:** with `MAX_HOLD`=M, a timed-out grant is visible for exactly M cycles.
- **Output registers:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared definitions file** holds:
  - The state encoding, with IDLE=1'b0 and BUSY=1'b1.
  - The requester count constant, NREQ=8, shared with the encoder.
- **Sub-module `rr_pick8`:** purely combinational. Inputs are `req[7:0]` and `ptr[2:0]`; output is a one-hot pick. It is implemented as a double-width mask-and-priority scan.
- **Top level:** contains the FSM, `ptr`, `cnt`, and the output registers.

## Test plan
- **Reset and idle:** deassert `rst_n` with `req`=8'h00 → `grant`=8'h00, `grant_valid`=0 indefinitely, and `timeout` never fires.
- **Priority from pointer and wrap:** `req`=8'h81 after reset (`ptr`=0) → `grant`=8'h01 one cycle later. Pulse `release` → one cycle of 8'h00, then `grant`=8'h80.
- **Full rotation:** `req`=8'hFF held, `release` pulsed on the first cycle of each grant → sequence 01,00,02,00,04,…,80,00,01.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h10, no `release` → 8'h10 held exactly 4 cycles, then 8'h00 with `timeout`=1 for 1 cycle. A subsequent `req`=8'h11 → `grant`=8'h01 (`ptr`=5 wraps).
- **Release at expiry:** `MAX_HOLD`=4, `release` asserted on the 4th grant cycle → grant clears, `timeout` stays 0.
- **Reset mid-BUSY:** `grant`=8'h08, then assert `rst_n`=0 mid-cycle → `grant`=0 immediately without a clock edge. After reset release with `req`=8'hFF → `grant`=8'h01.
